// File: rtl/pktctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pktctrl_pkg
// Brief    : Shared mode encodings and FSM state type for the source selector.
// Revision : 1.0 - initial release
// ============================================================================
package pktctrl_pkg;

    // Mode word is {self_test, 96path}
    localparam logic [1:0] MODE_ADC48 = 2'b00;
    localparam logic [1:0] MODE_ADC96 = 2'b01;
    localparam logic [1:0] MODE_GEN48 = 2'b10;
    localparam logic [1:0] MODE_GEN96 = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_src_sel_v2_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_src_sel_v2_if
// Brief    : Control, lane data and output bundle of the ADC source selector.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_src_sel_v2_if #(
    parameter int DW    = 36,
    parameter int NLANE = 24
);
    logic                    rf_self_test_mode;
    logic                    rf_96path_en;
    logic                    sof_i;
    logic [NLANE*DW-1:0]     ana_adc_data;
    logic [NLANE/2*DW-1:0]   ana_adc48_data;
    logic [NLANE*DW-1:0]     pkt_gen_data;
    logic [NLANE/2*DW-1:0]   pkt_gen_48data;
    logic [NLANE*DW-1:0]     adc_data;
    logic                    adc_data_vld;
    logic                    sof_o;
    logic [NLANE-1:0]        lane_en;
    logic [1:0]              mode_cur;
    logic                    switch_busy;

    modport master (
        output rf_self_test_mode, rf_96path_en, sof_i,
        output ana_adc_data, ana_adc48_data, pkt_gen_data, pkt_gen_48data,
        input  adc_data, adc_data_vld, sof_o, lane_en, mode_cur, switch_busy
    );

    modport slave (
        input  rf_self_test_mode, rf_96path_en, sof_i,
        input  ana_adc_data, ana_adc48_data, pkt_gen_data, pkt_gen_48data,
        output adc_data, adc_data_vld, sof_o, lane_en, mode_cur, switch_busy
    );
endinterface
`default_nettype wire

// File: rtl/adc_src_sel_v2_sync.sv
`default_nettype none
// ============================================================================
// Module   : cfg_sync2
// Brief    : Generic N-bit two-flop synchroniser, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_sync2 #(
    parameter int W = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [W-1:0] d,
    output logic      [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule
`default_nettype wire

// File: rtl/adc_src_sel_v2.sv
`default_nettype none
// ============================================================================
// Module   : adc_src_sel_v2
// Brief    : Per-lane ADC / packet-generator source selector with frame-aligned
//            mode switching and zero-filled flush window.
// Revision : 1.0 - initial release
// ============================================================================
module adc_src_sel_v2
    import pktctrl_pkg::*;
#(
    parameter int DW         = 36,
    parameter int NLANE      = 24,
    parameter int SETTLE_CYC = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    adc_src_sel_v2_if.slave bus
);
    localparam int            HALF     = NLANE / 2;
    localparam int            CW       = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);

    logic [1:0]          cfg_s;
    state_t              state;
    logic [CW-1:0]       cnt;
    logic [1:0]          mode_cur;
    logic [NLANE*DW-1:0] data_q;
    logic                vld_q;
    logic                sof_q;
    logic [NLANE-1:0]    en_q;
    logic                busy_q;

    cfg_sync2 #(.W(2)) u_cfg_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.rf_self_test_mode, bus.rf_96path_en}),
        .q     (cfg_s)
    );

    // On the flush exit cycle the output register is loaded with the new mode
    logic       flush_done;
    logic [1:0] sel_mode;
    logic       cfg_diff;
    assign flush_done = (state == ST_FLUSH) && (cnt == '0);
    assign sel_mode   = flush_done ? cfg_s : mode_cur;
    assign cfg_diff   = (cfg_s != mode_cur);

    logic [NLANE*DW-1:0] mux_data;
    logic [NLANE-1:0]    mux_en;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        logic [DW-1:0] full_src;
        assign full_src = sel_mode[1] ? bus.pkt_gen_data[i*DW +: DW]
                                      : bus.ana_adc_data[i*DW +: DW];
        if (i < HALF) begin : g_low
            logic [DW-1:0] half_src;
            assign half_src = sel_mode[1] ? bus.pkt_gen_48data[i*DW +: DW]
                                          : bus.ana_adc48_data[i*DW +: DW];
            assign mux_data[i*DW +: DW] = sel_mode[0] ? full_src : half_src;
            assign mux_en[i]            = 1'b1;
        end else begin : g_high
            assign mux_data[i*DW +: DW] = sel_mode[0] ? full_src : '0;
            assign mux_en[i]            = sel_mode[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            cnt      <= '0;
            mode_cur <= MODE_ADC48;
            data_q   <= '0;
            vld_q    <= 1'b0;
            sof_q    <= 1'b0;
            en_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            // Pass-through by default; flush cycles override with zeros
            data_q <= mux_data;
            vld_q  <= 1'b1;
            sof_q  <= bus.sof_i;
            en_q   <= mux_en;
            busy_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (cfg_diff) begin
                        state  <= ST_WAIT_SOF;
                        busy_q <= 1'b1;
                    end
                end
                ST_WAIT_SOF: begin
                    if (!cfg_diff) begin
                        state <= ST_RUN;
                    end else if (bus.sof_i) begin
                        state  <= ST_FLUSH;
                        cnt    <= CNT_LOAD;
                        data_q <= '0;
                        vld_q  <= 1'b0;
                        sof_q  <= 1'b0;
                        en_q   <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        mode_cur <= cfg_s;
                        state    <= ST_RUN;
                    end else begin
                        cnt    <= cnt - CW'(1);
                        data_q <= '0;
                        vld_q  <= 1'b0;
                        sof_q  <= 1'b0;
                        en_q   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.adc_data     = data_q;
    assign bus.adc_data_vld = vld_q;
    assign bus.sof_o        = sof_q;
    assign bus.lane_en      = en_q;
    assign bus.mode_cur     = mode_cur;
    assign bus.switch_busy  = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_adc_src_sel_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_src_sel_v2
// Brief    : Self-checking bench for adc_src_sel_v2 against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_src_sel_v2;
    localparam int DW         = 36;
    localparam int NLANE      = 24;
    localparam int HALF       = NLANE / 2;
    localparam int SETTLE_CYC = 4;

    typedef logic [NLANE*DW-1:0] wide_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_src_sel_v2_if #(.DW(DW), .NLANE(NLANE)) bus ();

    adc_src_sel_v2 #(.DW(DW), .NLANE(NLANE), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] ana  [NLANE];
    logic [DW-1:0] ana48[HALF];
    logic [DW-1:0] pg   [NLANE];
    logic [DW-1:0] pg48 [HALF];

    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            bus.ana_adc_data[i*DW +: DW] = ana[i];
            bus.pkt_gen_data[i*DW +: DW] = pg[i];
        end
        for (int k = 0; k < HALF; k++) begin
            bus.ana_adc48_data[k*DW +: DW] = ana48[k];
            bus.pkt_gen_48data[k*DW +: DW] = pg48[k];
        end
    end

    int n_asrt = 0;
    int n_fail = 0;
    int pat = 0;
    int vld_low_cnt, busy_cnt, sofo_cnt;

    // Reference model: applied mode, pending-change flag, remaining flush cycles
    logic [1:0] m_mode, m_h0, m_h1;
    bit         m_pend;
    int         m_flush;
    wide_t            e_data;
    logic             e_vld, e_sof, e_busy;
    logic [NLANE-1:0] e_en;

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wide_t exp_data(input logic [1:0] m);
        wide_t v = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (m[0])          v[i*DW +: DW] = m[1] ? pg[i] : ana[i];
            else if (i < HALF) v[i*DW +: DW] = m[1] ? pg48[i] : ana48[i];
        end
        return v;
    endfunction

    function automatic logic [NLANE-1:0] exp_en(input logic [1:0] m);
        logic [NLANE-1:0] v = '0;
        for (int i = 0; i < NLANE; i++) v[i] = m[0] || (i < HALF);
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 2'b00; m_h0 = 2'b00; m_h1 = 2'b00; m_pend = 0; m_flush = 0;
        e_data = '0; e_vld = 0; e_sof = 0; e_busy = 0; e_en = '0;
    endtask

    task automatic set_live(input bit busy);
        e_data = exp_data(m_mode); e_vld = 1; e_sof = bus.sof_i;
        e_en = exp_en(m_mode); e_busy = busy;
    endtask

    task automatic set_zero();
        e_data = '0; e_vld = 0; e_sof = 0; e_en = '0; e_busy = 1;
    endtask

    // Evaluated with the pre-edge inputs; cfg seen by the FSM is rf from two edges back
    task automatic model_edge();
        logic [1:0] cfg;
        cfg  = m_h1;
        m_h1 = m_h0;
        m_h0 = {bus.rf_self_test_mode, bus.rf_96path_en};
        if (m_flush > 0) begin
            m_flush--;
            if (m_flush == 0) begin
                m_mode = cfg; m_pend = 0; set_live(0);
            end else begin
                set_zero();
            end
        end else if (m_pend && cfg != m_mode && bus.sof_i) begin
            m_flush = SETTLE_CYC;
            set_zero();
        end else begin
            m_pend = (cfg != m_mode);
            set_live(m_pend);
        end
    endtask

    task automatic fill_data();
        logic [63:0] r;
        for (int i = 0; i < NLANE; i++) begin
            r = {$urandom(), $urandom()}; pg[i] = r[DW-1:0];
            r = {$urandom(), $urandom()}; ana[i] = r[DW-1:0];
            if (pat == 1) ana[i] = DW'(i);
        end
        for (int k = 0; k < HALF; k++) begin
            r = {$urandom(), $urandom()}; pg48[k] = r[DW-1:0];
            r = {$urandom(), $urandom()}; ana48[k] = r[DW-1:0];
            if (pat == 1) ana48[k] = DW'(36'h100 + k);
        end
    endtask

    task automatic check_all();
        chk("adc_data", bus.adc_data, e_data);
        chk("adc_data_vld", wide_t'(bus.adc_data_vld), wide_t'(e_vld));
        chk("sof_o", wide_t'(bus.sof_o), wide_t'(e_sof));
        chk("lane_en", wide_t'(bus.lane_en), wide_t'(e_en));
        chk("mode_cur", wide_t'(bus.mode_cur), wide_t'(m_mode));
        chk("switch_busy", wide_t'(bus.switch_busy), wide_t'(e_busy));
        if (!bus.adc_data_vld) vld_low_cnt++;
        if (bus.switch_busy)   busy_cnt++;
        if (bus.sof_o)         sofo_cnt++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, bus.adc_data, '0);
        chk({tag, "_vld"}, wide_t'(bus.adc_data_vld), '0);
        chk({tag, "_sof"}, wide_t'(bus.sof_o), '0);
        chk({tag, "_en"}, wide_t'(bus.lane_en), '0);
        chk({tag, "_mode"}, wide_t'(bus.mode_cur), '0);
        chk({tag, "_busy"}, wide_t'(bus.switch_busy), '0);
    endtask

    task automatic cyc(input logic [1:0] rf, input logic sof);
        bus.rf_self_test_mode = rf[1];
        bus.rf_96path_en      = rf[0];
        bus.sof_i             = sof;
        fill_data();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr_cnt();
        vld_low_cnt = 0; busy_cnt = 0; sofo_cnt = 0;
    endtask

    task automatic switch_to(input logic [1:0] rf, input int post);
        repeat (4) cyc(rf, 1'b0);
        clr_cnt();
        cyc(rf, 1'b1);
        repeat (post) cyc(rf, 1'b0);
    endtask

    initial begin
        bus.rf_self_test_mode = 0;
        bus.rf_96path_en      = 0;
        bus.sof_i             = 0;
        fill_data();
        model_reset();
        clr_cnt();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // 1: ADC48 -> ADC96 with lane-index pattern
        pat = 1;
        switch_to(2'b01, 6);
        chk("t1_flush_len", wide_t'(vld_low_cnt), wide_t'(SETTLE_CYC));
        chk("t1_lane5", wide_t'(bus.adc_data[5*DW +: DW]), wide_t'(36'h5));
        chk("t1_lane_en", wide_t'(bus.lane_en), wide_t'(24'hFFFFFF));
        chk("t1_mode", wide_t'(bus.mode_cur), wide_t'(2'b01));

        // 2: ADC96 -> ADC48
        switch_to(2'b00, 6);
        chk("t2_lane0", wide_t'(bus.adc_data[0 +: DW]), wide_t'(36'h100));
        chk("t2_lane11", wide_t'(bus.adc_data[11*DW +: DW]), wide_t'(36'h10B));
        chk("t2_lane12", wide_t'(bus.adc_data[12*DW +: DW]), '0);
        chk("t2_lane23", wide_t'(bus.adc_data[23*DW +: DW]), '0);
        chk("t2_lane_en", wide_t'(bus.lane_en), wide_t'(24'h000FFF));

        // 3: cancelled change, no sof
        pat = 0;
        clr_cnt();
        repeat (2) cyc(2'b10, 1'b0);
        repeat (6) cyc(2'b00, 1'b0);
        chk("t3_vld_low", wide_t'(vld_low_cnt), '0);
        chk("t3_busy_cycles", wide_t'(busy_cnt), wide_t'(2));
        chk("t3_mode", wide_t'(bus.mode_cur), wide_t'(2'b00));

        // 4: rf retargeted to GEN96 while flushing
        repeat (4) cyc(2'b10, 1'b0);
        clr_cnt();
        cyc(2'b10, 1'b1);
        repeat (6) cyc(2'b11, 1'b0);
        chk("t4_flush_len", wide_t'(vld_low_cnt), wide_t'(SETTLE_CYC));
        chk("t4_mode", wide_t'(bus.mode_cur), wide_t'(2'b11));

        // 5: reset in the middle of a flush
        repeat (4) cyc(2'b01, 1'b0);
        cyc(2'b01, 1'b1);
        cyc(2'b01, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("t5_held");
        rst_n = 1'b1;
        switch_to(2'b01, 6);
        chk("t5_flush_len", wide_t'(vld_low_cnt), wide_t'(SETTLE_CYC));
        chk("t5_mode", wide_t'(bus.mode_cur), wide_t'(2'b01));

        // 6: periodic sof, then a switch whose trigger sof is swallowed
        clr_cnt();
        for (int p = 0; p < 5; p++) begin
            cyc(2'b01, 1'b1);
            repeat (7) cyc(2'b01, 1'b0);
        end
        chk("t6_sof_fwd", wide_t'(sofo_cnt), wide_t'(5));
        clr_cnt();
        for (int p = 0; p < 4; p++) begin
            cyc(2'b11, 1'b1);
            repeat (7) cyc(2'b11, 1'b0);
        end
        chk("t6_sof_suppr", wide_t'(sofo_cnt), wide_t'(3));
        chk("t6_mode", wide_t'(bus.mode_cur), wide_t'(2'b11));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
